// File: rtl/demux_1x2_stream.sv
// rtl/demux_1x2_stream.sv - registered 1-to-2 stream demultiplexer with per-output beat counters
module demux_1x2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count,
  output logic             turn
);

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // Output A holding register
  logic [WIDTH-1:0] a_data_q,  a_data_d;
  logic             a_valid_q, a_valid_d;
  logic [7:0]       a_count_q, a_count_d;

  // Output B holding register
  logic [WIDTH-1:0] b_data_q,  b_data_d;
  logic             b_valid_q, b_valid_d;
  logic [7:0]       b_count_q, b_count_d;

  // Alternation pointer (1 = A is next)
  logic turn_q, turn_d;

  // Handshake decode
  logic tgt_is_a;
  logic tgt_valid;
  logic tgt_ready;
  logic accept;
  logic accept_a;
  logic accept_b;
  logic xfer_a;
  logic xfer_b;

  // Pick the destination; in_valid deliberately plays no part so in_ready never depends on it
  always_comb begin
    tgt_is_a  = mode ? turn_q : in_sel;
    tgt_valid = tgt_is_a ? a_valid_q : b_valid_q;
    tgt_ready = tgt_is_a ? a_ready   : b_ready;
    // A full target may still take a beat when it drains in the same cycle
    in_ready  = !rst && (!tgt_valid || tgt_ready);
  end

  // Split the accept toward one side and detect downstream transfers
  always_comb begin
    accept   = in_valid && in_ready;
    accept_a = accept && tgt_is_a;
    accept_b = accept && !tgt_is_a;
    xfer_a   = a_valid_q && a_ready;
    xfer_b   = b_valid_q && b_ready;
  end

  // Next state of output A: refill wins over drain, otherwise hold
  always_comb begin
    a_data_d  = a_data_q;
    a_valid_d = a_valid_q;
    a_count_d = a_count_q;
    if (accept_a) begin
      a_data_d  = in_data;
      a_valid_d = 1'b1;
    end else if (xfer_a) begin
      a_valid_d = 1'b0;
    end
    if (xfer_a && (a_count_q != COUNT_MAX)) begin
      a_count_d = a_count_q + 8'd1;
    end
  end

  // Next state of output B: refill wins over drain, otherwise hold
  always_comb begin
    b_data_d  = b_data_q;
    b_valid_d = b_valid_q;
    b_count_d = b_count_q;
    if (accept_b) begin
      b_data_d  = in_data;
      b_valid_d = 1'b1;
    end else if (xfer_b) begin
      b_valid_d = 1'b0;
    end
    if (xfer_b && (b_count_q != COUNT_MAX)) begin
      b_count_d = b_count_q + 8'd1;
    end
  end

  // Alternation only advances on beats actually taken while alternating
  always_comb begin
    turn_d = turn_q;
    if (mode && accept) begin
      turn_d = ~turn_q;
    end
  end

  // State registers; reset discards any buffered beats
  always_ff @(posedge clk) begin
    if (rst) begin
      a_data_q  <= '0;
      a_valid_q <= 1'b0;
      a_count_q <= 8'd0;
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
      b_count_q <= 8'd0;
      turn_q    <= 1'b1;
    end else begin
      a_data_q  <= a_data_d;
      a_valid_q <= a_valid_d;
      a_count_q <= a_count_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
      b_count_q <= b_count_d;
      turn_q    <= turn_d;
    end
  end

  // Drive outputs straight from the registers
  always_comb begin
    a_data  = a_data_q;
    a_valid = a_valid_q;
    a_count = a_count_q;
    b_data  = b_data_q;
    b_valid = b_valid_q;
    b_count = b_count_q;
    turn    = turn_q;
  end

endmodule
